tdm_demux_4: RTL and testbench

Receive-side companion to the 4:1 mux: takes a single time-division-multiplexed stream in which a transmitter rotates its select through lanes 0..3, and recovers the four lanes. Frame alignment comes from a start-of-frame marker. Each lane is presented on its own registered output with a per-lane strobe. A frame-coherent snapshot of all four lanes is also provided, updated once per complete frame. Sits at the far end of any link fed by a select-counter-driven 4:1 mux.

---
 rtl/tdm_demux_4_pkg.sv | 23 ++
 rtl/tdm_demux_4_slot_counter.sv | 38 +++
 rtl/tdm_demux_4.sv | 149 ++++++++++++++
 tb/tb_tdm_demux_4.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux_4_pkg.sv
// Shared definitions for the 4-lane TDM demultiplexer: state encoding,
// slot constants and the mux-compatible select mapping.
package tdm_demux_4_pkg;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam int NUM_LANES = 4;

   localparam logic [1:0] SLOT0 = 2'd0;
   localparam logic [1:0] SLOT1 = 2'd1;
   localparam logic [1:0] SLOT2 = 2'd2;
   localparam logic [1:0] SLOT3 = 2'd3;

   // The transmit mux decodes {s0,s1} with s0 as the MSB, so slot n maps
   // straight onto select value n.
   function automatic logic [1:0] sel_of_slot(input logic [1:0] slot);
      return {slot[1], slot[0]};
   endfunction

endpackage

// File: rtl/tdm_demux_4_slot_counter.sv
// Two-bit wrapping slot counter: clear to slot 0, load slot 1 after a
// lane-0 beat, or advance by one on an accepted beat.
module slot_counter
   import tdm_demux_4_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       load1,
   input  logic       en,
   output logic [1:0] slot
);

   logic [1:0] slot_reg;
   logic [1:0] slot_next;

   always_comb begin
      slot_next = slot_reg;
      if (clr) begin
         slot_next = SLOT0;
      end else if (load1) begin
         slot_next = SLOT1;
      end else if (en) begin
         slot_next = slot_reg + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_reg <= SLOT0;
      end else begin
         slot_reg <= slot_next;
      end
   end

   assign slot = slot_reg;

endmodule

// File: rtl/tdm_demux_4.sv
// Receive-side 4-lane TDM demultiplexer with SOF-based frame alignment,
// per-lane live outputs and a frame-coherent snapshot.
module tdm_demux_4
   import tdm_demux_4_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sof,
   output logic [WIDTH-1:0] lane0,
   output logic [WIDTH-1:0] lane1,
   output logic [WIDTH-1:0] lane2,
   output logic [WIDTH-1:0] lane3,
   output logic [3:0]       lane_stb,
   output logic [WIDTH-1:0] frame0,
   output logic [WIDTH-1:0] frame1,
   output logic [WIDTH-1:0] frame2,
   output logic [WIDTH-1:0] frame3,
   output logic             frame_done,
   output logic [1:0]       sel,
   output logic             locked,
   output logic             sync_err
);

   state_t           state_reg;
   state_t           state_next;
   logic [1:0]       slot;
   logic [3:0]       wr_lane;
   logic             frame_wr;
   logic             err_next;
   logic             ctr_clr;
   logic             ctr_load;
   logic             ctr_inc;

   logic [WIDTH-1:0] lane_reg  [NUM_LANES];
   logic [WIDTH-1:0] frame_reg [NUM_LANES];
   logic [3:0]       lane_stb_reg;
   logic             frame_done_reg;
   logic             sync_err_reg;

   slot_counter u_slot_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (ctr_clr),
      .load1 (ctr_load),
      .en    (ctr_inc),
      .slot  (slot)
   );

   // Every path into slot 3 starts from a lane-0 write, so reaching slot 3
   // in LOCKED always completes a coherent frame.
   always_comb begin
      state_next = state_reg;
      wr_lane    = 4'b0000;
      frame_wr   = 1'b0;
      err_next   = 1'b0;
      ctr_clr    = 1'b0;
      ctr_load   = 1'b0;
      ctr_inc    = 1'b0;
      if (in_valid) begin
         case (state_reg)
            HUNT: begin
               if (in_sof) begin
                  wr_lane    = 4'b0001;
                  ctr_load   = 1'b1;
                  state_next = LOCKED;
               end
            end
            LOCKED: begin
               if (in_sof) begin
                  wr_lane  = 4'b0001;
                  ctr_load = 1'b1;
                  err_next = (slot != SLOT0);
               end else if (slot == SLOT0) begin
                  err_next   = 1'b1;
                  ctr_clr    = 1'b1;
                  state_next = HUNT;
               end else begin
                  wr_lane  = 4'b0001 << slot;
                  ctr_inc  = 1'b1;
                  frame_wr = (slot == SLOT3);
               end
            end
            default: begin
               state_next = HUNT;
               ctr_clr    = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= HUNT;
         lane_stb_reg   <= 4'b0000;
         frame_done_reg <= 1'b0;
         sync_err_reg   <= 1'b0;
      end else begin
         state_reg      <= state_next;
         lane_stb_reg   <= wr_lane;
         frame_done_reg <= frame_wr;
         sync_err_reg   <= err_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               lane_reg[gi] <= '0;
            end else if (wr_lane[gi]) begin
               lane_reg[gi] <= in_data;
            end
         end

         // Lane 3 is snapshotted straight from the incoming beat.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               frame_reg[gi] <= '0;
            end else if (frame_wr) begin
               if (gi == NUM_LANES - 1) begin
                  frame_reg[gi] <= in_data;
               end else begin
                  frame_reg[gi] <= lane_reg[gi];
               end
            end
         end
      end
   endgenerate

   assign lane0      = lane_reg[0];
   assign lane1      = lane_reg[1];
   assign lane2      = lane_reg[2];
   assign lane3      = lane_reg[3];
   assign frame0     = frame_reg[0];
   assign frame1     = frame_reg[1];
   assign frame2     = frame_reg[2];
   assign frame3     = frame_reg[3];
   assign lane_stb   = lane_stb_reg;
   assign frame_done = frame_done_reg;
   assign sync_err   = sync_err_reg;
   assign locked     = (state_reg == LOCKED);
   assign sel        = (state_reg == LOCKED) ? sel_of_slot(slot) : SLOT0;

endmodule

// File: tb/tb_tdm_demux_4.sv
// Self-checking bench for tdm_demux_4: directed scenarios plus randomized
// beats against a frame-position reference model.
module tb_tdm_demux_4;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         in_sof;
   logic [W-1:0] lane0, lane1, lane2, lane3;
   logic [3:0]   lane_stb;
   logic [W-1:0] frame0, frame1, frame2, frame3;
   logic         frame_done;
   logic [1:0]   sel;
   logic         locked;
   logic         sync_err;

   int checks;
   int failures;

   // reference model state
   bit           m_locked;
   int           m_pos;
   logic [W-1:0] m_lane  [4];
   logic [W-1:0] m_frame [4];
   logic [3:0]   m_stb;
   bit           m_fd;
   bit           m_err;

   logic [W-1:0] dut_lane  [4];
   logic [W-1:0] dut_frame [4];

   assign dut_lane[0]  = lane0;
   assign dut_lane[1]  = lane1;
   assign dut_lane[2]  = lane2;
   assign dut_lane[3]  = lane3;
   assign dut_frame[0] = frame0;
   assign dut_frame[1] = frame1;
   assign dut_frame[2] = frame2;
   assign dut_frame[3] = frame3;

   tdm_demux_4 #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_sof     (in_sof),
      .lane0      (lane0),
      .lane1      (lane1),
      .lane2      (lane2),
      .lane3      (lane3),
      .lane_stb   (lane_stb),
      .frame0     (frame0),
      .frame1     (frame1),
      .frame2     (frame2),
      .frame3     (frame3),
      .frame_done (frame_done),
      .sel        (sel),
      .locked     (locked),
      .sync_err   (sync_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_clear();
      m_locked = 0;
      m_pos    = 0;
      m_stb    = 4'b0000;
      m_fd     = 0;
      m_err    = 0;
      for (int i = 0; i < 4; i++) begin
         m_lane[i]  = '0;
         m_frame[i] = '0;
      end
   endtask

   // Drive one cycle of input, advance one edge, update the model.
   task automatic beat(input bit v, input logic [W-1:0] d, input bit s);
      in_valid = v;
      in_data  = d;
      in_sof   = s;
      @(posedge clk);
      #1;
      m_stb = 4'b0000;
      m_fd  = 0;
      m_err = 0;
      if (v) begin
         if (s) begin
            // any SOF beat starts a new frame; mid-frame SOF is an error
            if (m_locked && m_pos != 0) m_err = 1;
            m_locked  = 1;
            m_lane[0] = d;
            m_stb[0]  = 1'b1;
            m_pos     = 1;
         end else if (m_locked) begin
            if (m_pos == 0) begin
               m_err    = 1;
               m_locked = 0;
            end else begin
               m_lane[m_pos] = d;
               m_stb[m_pos]  = 1'b1;
               if (m_pos == 3) begin
                  for (int i = 0; i < 4; i++) m_frame[i] = m_lane[i];
                  m_fd = 1;
               end
               m_pos = (m_pos + 1) % 4;
            end
         end
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
      $display("beat v=%0d d=%h sof=%0d -> stb=%b fd=%0d err=%0d locked=%0d sel=%0d",
               v, d, s, lane_stb, frame_done, sync_err, locked, sel);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      in_valid = 1'b0;
      in_data  = '0;
      in_sof   = 1'b0;
      do_reset();
      #1;
      checks++;
      if ({lane0, lane1, lane2, lane3, frame0, frame1, frame2, frame3} !== '0) begin
         failures++;
         $display("FAIL reset_data got=%h%h%h%h_%h%h%h%h want=0",
                  lane0, lane1, lane2, lane3, frame0, frame1, frame2, frame3);
      end
      checks++;
      if ({lane_stb, frame_done, sync_err, locked, sel} !== 9'b0) begin
         failures++;
         $display("FAIL reset_ctrl got stb=%b fd=%b err=%b locked=%b sel=%b want all 0",
                  lane_stb, frame_done, sync_err, locked, sel);
      end
   endtask

   task automatic test_frame();
      logic [W-1:0] vals [4];
      vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         beat(1'b1, vals[i], i == 0);
         checks++;
         if (lane_stb !== (4'b0001 << i) || locked !== 1'b1) begin
            failures++;
            $display("FAIL frame_stb%0d got stb=%b locked=%b want stb=%b locked=1",
                     i, lane_stb, locked, 4'b0001 << i);
         end
         checks++;
         if (frame_done !== (i == 3)) begin
            failures++;
            $display("FAIL frame_done%0d got=%b want=%b", i, frame_done, i == 3);
         end
      end
      checks++;
      if ({frame0, frame1, frame2, frame3} !== 32'h11223344) begin
         failures++;
         $display("FAIL frame_snapshot got=%h%h%h%h want=11223344", frame0, frame1, frame2, frame3);
      end
   endtask

   task automatic test_hunt_drop();
      do_reset();
      beat(1'b1, 8'h55, 1'b0);
      beat(1'b1, 8'h66, 1'b0);
      checks++;
      if (lane_stb !== 4'b0000 || sync_err !== 1'b0 || locked !== 1'b0 || lane0 !== 8'h00) begin
         failures++;
         $display("FAIL hunt_drop got stb=%b err=%b locked=%b lane0=%h want 0000/0/0/00",
                  lane_stb, sync_err, locked, lane0);
      end
      beat(1'b1, 8'h11, 1'b1);
      checks++;
      if (lane0 !== 8'h11 || locked !== 1'b1 || lane_stb !== 4'b0001 || sel !== 2'b01) begin
         failures++;
         $display("FAIL hunt_lock got lane0=%h locked=%b stb=%b sel=%b want 11/1/0001/01",
                  lane0, locked, lane_stb, sel);
      end
   endtask

   task automatic test_resync();
      do_reset();
      beat(1'b1, 8'h11, 1'b1);
      beat(1'b1, 8'h22, 1'b0);
      beat(1'b1, 8'h33, 1'b0);
      beat(1'b1, 8'h44, 1'b0);
      beat(1'b1, 8'h11, 1'b1);
      beat(1'b1, 8'h22, 1'b0);
      beat(1'b1, 8'h99, 1'b1);
      checks++;
      if (sync_err !== 1'b1 || lane0 !== 8'h99 || sel !== 2'b01 || frame_done !== 1'b0) begin
         failures++;
         $display("FAIL resync got err=%b lane0=%h sel=%b fd=%b want 1/99/01/0",
                  sync_err, lane0, sel, frame_done);
      end
      checks++;
      if ({frame0, frame1, frame2, frame3} !== 32'h11223344) begin
         failures++;
         $display("FAIL resync_frame got=%h%h%h%h want=11223344", frame0, frame1, frame2, frame3);
      end
   endtask

   task automatic test_slot0_nosof();
      do_reset();
      for (int i = 0; i < 4; i++) beat(1'b1, 8'(8'h10 + i), i == 0);
      beat(1'b1, 8'h77, 1'b0);
      checks++;
      if (sync_err !== 1'b1 || locked !== 1'b0 || sel !== 2'b00 || lane_stb !== 4'b0000) begin
         failures++;
         $display("FAIL slot0_nosof got err=%b locked=%b sel=%b stb=%b want 1/0/00/0000",
                  sync_err, locked, sel, lane_stb);
      end
      beat(1'b0, 8'h00, 1'b0);
      checks++;
      if (sync_err !== 1'b0) begin
         failures++;
         $display("FAIL err_one_cycle got=%b want=0", sync_err);
      end
   endtask

   task automatic test_gaps();
      logic [W-1:0] vals [4];
      vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         beat(1'b1, vals[i], i == 0);
         checks++;
         if (lane_stb !== (4'b0001 << i) || frame_done !== (i == 3)) begin
            failures++;
            $display("FAIL gap_beat%0d got stb=%b fd=%b want stb=%b fd=%b",
                     i, lane_stb, frame_done, 4'b0001 << i, i == 3);
         end
         beat(1'b0, 8'hEE, 1'b1);
         checks++;
         if (lane_stb !== 4'b0000 || frame_done !== 1'b0 || sync_err !== 1'b0) begin
            failures++;
            $display("FAIL gap_idle%0d got stb=%b fd=%b err=%b want 0000/0/0",
                     i, lane_stb, frame_done, sync_err);
         end
      end
      checks++;
      if ({frame0, frame1, frame2, frame3} !== 32'h11223344 || sel !== 2'b00 || locked !== 1'b1) begin
         failures++;
         $display("FAIL gap_frame got=%h%h%h%h sel=%b locked=%b want 11223344/00/1",
                  frame0, frame1, frame2, frame3, sel, locked);
      end
   endtask

   task automatic test_reset_midframe();
      do_reset();
      beat(1'b1, 8'hA1, 1'b1);
      beat(1'b1, 8'hA2, 1'b0);
      rst_n = 1'b0;
      #2;
      model_clear();
      checks++;
      if ({lane0, lane1, locked, sel, lane_stb} !== '0) begin
         failures++;
         $display("FAIL async_reset got lane0=%h lane1=%h locked=%b sel=%b stb=%b want 0",
                  lane0, lane1, locked, sel, lane_stb);
      end
      @(negedge clk);
      rst_n = 1'b1;
      beat(1'b1, 8'hB3, 1'b0);
      beat(1'b1, 8'hB0, 1'b1);
      checks++;
      if (locked !== 1'b1 || lane0 !== 8'hB0 || lane2 !== 8'h00 || sync_err !== 1'b0) begin
         failures++;
         $display("FAIL relock got locked=%b lane0=%h lane2=%h err=%b want 1/B0/00/0",
                  locked, lane0, lane2, sync_err);
      end
   endtask

   task automatic test_random();
      bit v, s;
      logic [W-1:0] d;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         v = ($urandom_range(3, 0) != 0);
         d = W'($urandom);
         s = (m_pos == 0);
         if ($urandom_range(9, 0) == 0) s = ~s;
         beat(v, d, s);
         checks++;
         if (lane_stb !== m_stb || frame_done !== m_fd || sync_err !== m_err) begin
            failures++;
            $display("FAIL rand_pulse%0d got stb=%b fd=%b err=%b want stb=%b fd=%b err=%b",
                     n, lane_stb, frame_done, sync_err, m_stb, m_fd, m_err);
         end
         checks++;
         if (locked !== m_locked || sel !== (m_locked ? 2'(m_pos) : 2'b00)) begin
            failures++;
            $display("FAIL rand_state%0d got locked=%b sel=%b want locked=%b sel=%0d",
                     n, locked, sel, m_locked, m_locked ? m_pos : 0);
         end
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut_lane[i] !== m_lane[i] || dut_frame[i] !== m_frame[i]) begin
               failures++;
               $display("FAIL rand_data%0d lane%0d got lane=%h frame=%h want lane=%h frame=%h",
                        n, i, dut_lane[i], dut_frame[i], m_lane[i], m_frame[i]);
            end
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      model_clear();
      test_reset();
      test_frame();
      test_hunt_drop();
      test_resync();
      test_slot0_nosof();
      test_gaps();
      test_reset_midframe();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
